// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: draw reads, clear sweep and game accesses,
// fixed priority draw > clear > game, fixed 3-cycle read return.
module board_mem_arbiter #(
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 4,
   parameter int CELLS     = 1536,
   parameter int CLR_VALUE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              draw_req,
   input  logic [ADDR_W-1:0] draw_addr,
   output logic              draw_valid,
   output logic [DATA_W-1:0] draw_rdata,
   input  logic              game_req,
   input  logic              game_we,
   input  logic [ADDR_W-1:0] game_addr,
   input  logic [DATA_W-1:0] game_wdata,
   output logic              game_gnt,
   output logic              game_rvalid,
   output logic [DATA_W-1:0] game_rdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DRAW = 2'd1,
      TAG_GAME = 2'd2
   } tag_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } clr_state_t;

   localparam logic [ADDR_W-1:0] CNT_END  = ADDR_W'(CELLS);
   localparam logic [DATA_W-1:0] CLR_CODE = DATA_W'(CLR_VALUE);

   clr_state_t        state;
   logic [ADDR_W-1:0] clr_cnt;
   tag_t              tag_mem;
   tag_t              tag_ret;
   logic              clr_act;
   logic              game_ok;

   // The clear contends in the same cycle clr_start is sampled, so its first
   // write lands on mem_* together with the rising clr_busy.
   always_comb begin
      clr_act = ((state == S_IDLE) && clr_start) ||
                ((state == S_CLEAR) && (clr_cnt != CNT_END));
      // NOTE: game_gnt is itself a blocker, so the request still held in the
      // grant cycle cannot issue a second access.
      game_ok = game_req && !draw_req && !clr_busy && !clr_act && !game_gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         clr_cnt  <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clr_start) begin
                  state    <= S_CLEAR;
                  clr_busy <= 1'b1;
                  clr_cnt  <= draw_req ? '0 : ADDR_W'(1);
               end
            end
            S_CLEAR: begin
               if (clr_cnt == CNT_END) begin
                  state    <= S_IDLE;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
                  clr_cnt  <= '0;
               end else if (!draw_req) begin
                  clr_cnt <= clr_cnt + ADDR_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         game_gnt  <= 1'b0;
         tag_mem   <= TAG_NONE;
      end else begin
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         game_gnt <= 1'b0;
         tag_mem  <= TAG_NONE;
         if (draw_req) begin
            mem_en   <= 1'b1;
            mem_addr <= draw_addr;
            tag_mem  <= TAG_DRAW;
         end else if (clr_act) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= (state == S_IDLE) ? '0 : clr_cnt;
            mem_wdata <= CLR_CODE;
         end else if (game_ok) begin
            mem_en    <= 1'b1;
            mem_we    <= game_we;
            mem_addr  <= game_addr;
            mem_wdata <= game_wdata;
            game_gnt  <= 1'b1;
            tag_mem   <= game_we ? TAG_NONE : TAG_GAME;
         end
      end
   end

   // Tag follows the access through the RAM's one-cycle read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_ret     <= TAG_NONE;
         draw_valid  <= 1'b0;
         draw_rdata  <= '0;
         game_rvalid <= 1'b0;
         game_rdata  <= '0;
      end else begin
         tag_ret     <= tag_mem;
         draw_valid  <= (tag_ret == TAG_DRAW);
         game_rvalid <= (tag_ret == TAG_GAME);
         if (tag_ret == TAG_DRAW) draw_rdata <= mem_rdata;
         if (tag_ret == TAG_GAME) game_rdata <= mem_rdata;
      end
   end

endmodule
